// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor and its synchronizer.
package pll_sup_pkg;

   typedef enum logic [1:0] {
      PLL_RST,
      WAIT_LOCK,
      QUALIFY,
      RUN
   } sup_state_t;

   // Width of the shared cycle counter: enough to hold the largest terminal count.
   function automatic int unsigned cycle_cnt_width(input int unsigned rst_cycles,
                                                   input int unsigned stable_cycles,
                                                   input int unsigned timeout_cycles);
      int unsigned m;
      m = rst_cycles;
      if (stable_cycles > m) m = stable_cycles;
      if (timeout_cycles > m) m = timeout_cycles;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer for an asynchronous status bit, cleared to 0 by reset.
module pll_lock_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_out
);

   logic [SYNC_STAGES-1:0] stages;

   always_ff @(posedge clk) begin
      if (!reset_n) stages <= '0;
      else          stages <= {stages[SYNC_STAGES-2:0], async_in};
   end

   assign sync_out = stages[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives PLL reset, qualifies a stable lock, releases the core reset and
// counts lock-loss / lock-timeout events. Runs on the free-running reference clock.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int unsigned SYNC_STAGES         = 2,
   parameter int unsigned PLL_RST_CYCLES      = 16,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 7425000,
   parameter int unsigned CNT_W               = 8
) (
   input  logic             clk_74a,
   input  logic             reset_n,
   input  logic             pll_locked,
   input  logic             force_relock,
   input  logic             clear_counts,
   output logic             pll_rst,
   output logic             core_reset_n,
   output logic             pll_ready,
   output logic [CNT_W-1:0] lock_loss_count,
   output logic [CNT_W-1:0] timeout_count
);

   localparam int unsigned CYC_W = cycle_cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                                   LOCK_TIMEOUT_CYCLES);
   localparam logic [CYC_W-1:0] RST_LAST     = CYC_W'(PLL_RST_CYCLES - 1);
   localparam logic [CYC_W-1:0] STABLE_LAST  = CYC_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT_CYCLES - 1);

   sup_state_t       state;
   logic [CYC_W-1:0] cyc_cnt;
   logic             locked_s;
   logic             timeout_evt;
   logic             loss_evt;

   pll_lock_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_lock_sync (
      .clk     (clk_74a),
      .reset_n (reset_n),
      .async_in(pll_locked),
      .sync_out(locked_s)
   );

   // force_relock pre-empts both events, so neither is counted when it wins.
   always_comb begin
      timeout_evt = (state == WAIT_LOCK) && !force_relock && !locked_s &&
                    (cyc_cnt == TIMEOUT_LAST);
      loss_evt    = (state == RUN) && !force_relock && !locked_s;
   end

   // Outputs default to the "not running" values and are set from the next state.
   always_ff @(posedge clk_74a) begin
      if (!reset_n) begin
         state        <= PLL_RST;
         cyc_cnt      <= '0;
         pll_rst      <= 1'b1;
         core_reset_n <= 1'b0;
         pll_ready    <= 1'b0;
      end else begin
         pll_rst      <= 1'b0;
         core_reset_n <= 1'b0;
         pll_ready    <= 1'b0;
         case (state)
            PLL_RST: begin
               if (cyc_cnt == RST_LAST) begin
                  state   <= WAIT_LOCK;
                  cyc_cnt <= '0;
               end else begin
                  pll_rst <= 1'b1;
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
               end
            end
            WAIT_LOCK: begin
               if (force_relock || (!locked_s && cyc_cnt == TIMEOUT_LAST)) begin
                  state   <= PLL_RST;
                  cyc_cnt <= '0;
                  pll_rst <= 1'b1;
               end else if (locked_s) begin
                  state   <= QUALIFY;
                  cyc_cnt <= '0;
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
               end
            end
            QUALIFY: begin
               if (force_relock) begin
                  state   <= PLL_RST;
                  cyc_cnt <= '0;
                  pll_rst <= 1'b1;
               end else if (!locked_s) begin
                  state   <= WAIT_LOCK;
                  cyc_cnt <= '0;
               end else if (cyc_cnt == STABLE_LAST) begin
                  state        <= RUN;
                  cyc_cnt      <= '0;
                  core_reset_n <= 1'b1;
                  pll_ready    <= 1'b1;
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
               end
            end
            RUN: begin
               if (force_relock) begin
                  state   <= PLL_RST;
                  cyc_cnt <= '0;
                  pll_rst <= 1'b1;
               end else if (!locked_s) begin
                  state   <= WAIT_LOCK;
                  cyc_cnt <= '0;
               end else begin
                  core_reset_n <= 1'b1;
                  pll_ready    <= 1'b1;
               end
            end
            default: begin
               state   <= PLL_RST;
               cyc_cnt <= '0;
               pll_rst <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_74a) begin
      if (!reset_n || clear_counts) begin
         lock_loss_count <= '0;
         timeout_count   <= '0;
      end else begin
         if (loss_evt && lock_loss_count != '1)
            lock_loss_count <= lock_loss_count + CNT_W'(1);
         if (timeout_evt && timeout_count != '1)
            timeout_count <= timeout_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: directed scenarios plus random lock activity.
module tb_pll_lock_supervisor;

   localparam int unsigned SYNC = 2;
   localparam int unsigned RSTC = 4;
   localparam int unsigned STAB = 8;
   localparam int unsigned TO   = 100;
   localparam int unsigned CW   = 2;
   localparam int unsigned CMAX = (1 << CW) - 1;

   logic          clk_74a = 1'b0;
   logic          reset_n, pll_locked, force_relock, clear_counts;
   logic          pll_rst, core_reset_n, pll_ready;
   logic [CW-1:0] lock_loss_count, timeout_count;

   always #5 clk_74a = ~clk_74a;

   pll_lock_supervisor #(
      .SYNC_STAGES        (SYNC),
      .PLL_RST_CYCLES     (RSTC),
      .LOCK_STABLE_CYCLES (STAB),
      .LOCK_TIMEOUT_CYCLES(TO),
      .CNT_W              (CW)
   ) dut (
      .clk_74a        (clk_74a),
      .reset_n        (reset_n),
      .pll_locked     (pll_locked),
      .force_relock   (force_relock),
      .clear_counts   (clear_counts),
      .pll_rst        (pll_rst),
      .core_reset_n   (core_reset_n),
      .pll_ready      (pll_ready),
      .lock_loss_count(lock_loss_count),
      .timeout_count  (timeout_count)
   );

   typedef struct {
      int unsigned cyc;
      logic        rst;
      logic        crn;
      logic        rdy;
      int unsigned loss;
      int unsigned tmo;
      string       tag;
   } exp_t;

   exp_t  sbq[$];
   int    checks   = 0;
   int    failures = 0;
   string tag      = "init";

   // Reference model: phase name, edge index of phase entry, and a delay line
   // standing in for the synchronizer latency.
   string       m_phase   = "RST";
   int unsigned m_cyc     = 0;
   int unsigned m_entered = 0;
   int unsigned m_loss    = 0;
   int unsigned m_tmo     = 0;
   bit          dl[$];

   function automatic void goto_phase(input string p);
      m_phase   = p;
      m_entered = m_cyc;
   endfunction

   function automatic void model_edge(input bit rn, input bit pl, input bit fr, input bit cc);
      bit ls, inc_t, inc_l;
      m_cyc++;
      inc_t = 1'b0;
      inc_l = 1'b0;
      if (!rn) begin
         goto_phase("RST");
         m_loss = 0;
         m_tmo  = 0;
         dl.delete();
         for (int i = 0; i < SYNC; i++) dl.push_back(1'b0);
         return;
      end
      ls = dl.pop_front();
      dl.push_back(pl);
      if (m_phase == "RST") begin
         if (m_cyc - m_entered == RSTC) goto_phase("WAIT");
      end else if (m_phase == "WAIT") begin
         if (fr) goto_phase("RST");
         else if (ls) goto_phase("QUAL");
         else if (m_cyc - m_entered == TO) begin goto_phase("RST"); inc_t = 1'b1; end
      end else if (m_phase == "QUAL") begin
         if (fr) goto_phase("RST");
         else if (!ls) goto_phase("WAIT");
         else if (m_cyc - m_entered == STAB) goto_phase("RUN");
      end else begin
         if (fr) goto_phase("RST");
         else if (!ls) begin goto_phase("WAIT"); inc_l = 1'b1; end
      end
      if (cc) begin
         m_loss = 0;
         m_tmo  = 0;
      end else begin
         if (inc_l && m_loss < CMAX) m_loss++;
         if (inc_t && m_tmo < CMAX) m_tmo++;
      end
   endfunction

   function automatic bit will_timeout();
      return (m_phase == "WAIT") && (m_cyc + 1 - m_entered == TO) && (dl[0] == 1'b0);
   endfunction

   task automatic step(input bit rn, input bit pl, input bit fr, input bit cc);
      exp_t e;
      @(negedge clk_74a);
      reset_n      = rn;
      pll_locked   = pl;
      force_relock = fr;
      clear_counts = cc;
      model_edge(rn, pl, fr, cc);
      e.cyc  = m_cyc;
      e.rst  = (m_phase == "RST");
      e.crn  = (m_phase == "RUN");
      e.rdy  = (m_phase == "RUN");
      e.loss = m_loss;
      e.tmo  = m_tmo;
      e.tag  = tag;
      sbq.push_back(e);
      @(posedge clk_74a);
      #1;
   endtask

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   initial begin : monitor
      exp_t e;
      logic [31:0] loss_w, tmo_w;
      forever begin
         @(posedge clk_74a);
         #1;
         if (sbq.size() > 0) begin
            e      = sbq.pop_front();
            loss_w = e.loss;
            tmo_w  = e.tmo;
            checks++;
            if (pll_rst !== e.rst || core_reset_n !== e.crn || pll_ready !== e.rdy ||
                lock_loss_count !== loss_w[CW-1:0] || timeout_count !== tmo_w[CW-1:0]) begin
               failures++;
               $display("FAIL sb_%s cyc=%0d got rst=%b crn=%b rdy=%b loss=%0d tmo=%0d want rst=%b crn=%b rdy=%b loss=%0d tmo=%0d",
                        e.tag, e.cyc, pll_rst, core_reset_n, pll_ready, lock_loss_count,
                        timeout_count, e.rst, e.crn, e.rdy, e.loss, e.tmo);
            end
         end
      end
   end

   initial begin : stimulus
      int  width, lat, hold;
      bit  found, pl;
      reset_n      = 1'b0;
      pll_locked   = 1'b0;
      force_relock = 1'b0;
      clear_counts = 1'b0;

      tag = "t1_bringup";
      repeat (3) step(0, 0, 0, 0);
      chk("t1_reset_pll_rst", pll_rst, 1);
      chk("t1_reset_core_reset_n", core_reset_n, 0);
      width = 1;
      for (int i = 0; i < 50; i++) begin
         step(1, 0, 0, 0);
         if (pll_rst !== 1'b1) break;
         width++;
      end
      chk("t1_pll_rst_width", width, RSTC);
      repeat (4) step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      lat = 0;
      for (int i = 0; i < 50; i++) begin
         if (core_reset_n === 1'b1) break;
         step(1, 1, 0, 0);
         lat++;
      end
      chk("t1_release_latency", lat, SYNC + STAB);
      chk("t1_pll_ready", pll_ready, 1);
      repeat (5) step(1, 1, 0, 0);

      tag = "t2_timeouts";
      step(0, 0, 0, 0);
      repeat (4 * (RSTC + TO) + 5) step(1, 0, 0, 0);
      chk("t2_timeout_saturated", timeout_count, CMAX);

      tag = "t3_lock_drop";
      repeat (SYNC + STAB + 5) step(1, 1, 0, 0);
      step(1, 0, 0, 0);
      repeat (2) step(1, 1, 0, 0);
      chk("t3_core_reset_low", core_reset_n, 0);
      chk("t3_lock_loss", lock_loss_count, 1);
      chk("t3_no_pll_rst", pll_rst, 0);
      repeat (SYNC + STAB + 5) step(1, 1, 0, 0);

      tag = "t4_glitch";
      step(1, 1, 1, 0);
      repeat (10) step(1, 0, 0, 0);
      repeat (5) step(1, 1, 0, 0);
      step(1, 0, 0, 0);
      repeat (SYNC + STAB + 5) step(1, 1, 0, 0);

      tag = "t5_priority";
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 1, 0);
      chk("t5_force_pll_rst", pll_rst, 1);
      chk("t5_loss_unchanged", lock_loss_count, 1);
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (will_timeout()) begin
            step(1, 0, 0, 1);
            found = 1'b1;
            break;
         end
         step(1, 0, 0, 0);
      end
      chk("t5_timeout_reached", found, 1);
      chk("t5_clear_wins", timeout_count, 0);

      tag = "t6_reset_qualify";
      repeat (TO + RSTC + 2) step(1, 0, 0, 0);
      for (int i = 0; i < 200; i++) begin
         if (m_phase == "QUAL" && m_cyc - m_entered >= 3) break;
         step(1, 1, 0, 0);
      end
      step(0, 1, 0, 0);
      chk("t6_pll_rst", pll_rst, 1);
      chk("t6_core_reset_n", core_reset_n, 0);
      chk("t6_timeout_count", timeout_count, 0);
      chk("t6_lock_loss_count", lock_loss_count, 0);

      tag = "t7_random";
      hold = 0;
      pl   = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            pl   = ($urandom_range(0, 3) != 0);
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                : int'($urandom_range(5, 150));
         end
         hold--;
         step(($urandom_range(0, 799) != 0), pl, ($urandom_range(0, 149) == 0),
              ($urandom_range(0, 199) == 0));
      end

      repeat (3) @(posedge clk_74a);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Consumer-side companion to the core PLL wrapper. It drives the PLL's rst input and watches its asynchronous locked output. It qualifies lock as stable, then releases a synchronous core reset. If lock is not acquired in time, it re-resets the PLL. It counts lock-loss and timeout events for the status registers. It runs on the bridge/reference clock domain, so it never depends on the PLL output clocks it supervises.

Parameters:
SYNC_STAGES, 2, flops in the synchronizer for pll_locked (>=2)
PLL_RST_CYCLES, 16, cycles pll_rst is held high per PLL reset pulse (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles needed before release (>=1)
LOCK_TIMEOUT_CYCLES, 7425000, max cycles in WAIT_LOCK before the PLL is re-reset (100 ms at 74.25 MHz)
CNT_W, 8, width of the event counters

Ports:
clk_74a  in  1  supervisor clock, free-running reference
reset_n  in  1  synchronous, active-low reset
pll_locked  in  1  PLL locked, asynchronous to clk_74a
force_relock  in  1  single-cycle request to re-reset the PLL
clear_counts  in  1  single-cycle request to zero both counters
pll_rst  out  1  to PLL rst, active high
core_reset_n  out  1  synchronous active-low reset for PLL-clocked logic
pll_ready  out  1  high only in RUN
lock_loss_count  out  CNT_W  number of RUN->lock-drop events, saturating
timeout_count  out  CNT_W  number of WAIT_LOCK timeouts, saturating

Behaviour:
- All outputs are registered.
- reset_n low at a clk_74a edge sets the following state:
  - state=PLL_RST, cycle counter=0, synchronizer flops=0
  - pll_rst=1, core_reset_n=0, pll_ready=0, both counts=0
- Reset mid-operation aborts everything immediately. No output glitch: pll_rst goes high on that same edge.
- locked_s is pll_locked after SYNC_STAGES flops. Only locked_s is used internally.
- States:
  - PLL_RST: pll_rst=1, core_reset_n=0. After PLL_RST_CYCLES cycles -> WAIT_LOCK, counter cleared.
  - WAIT_LOCK: pll_rst=0, core_reset_n=0. If locked_s=1 -> QUALIFY, counter cleared. Else if counter reaches LOCK_TIMEOUT_CYCLES-1 -> PLL_RST, timeout_count+1.
  - QUALIFY: core_reset_n=0. If locked_s=0 -> WAIT_LOCK, counter cleared; no event counted, and the timeout restarts. If locked_s=1 for LOCK_STABLE_CYCLES consecutive cycles -> RUN.
  - RUN: core_reset_n=1, pll_ready=1. If locked_s=0 -> WAIT_LOCK with lock_loss_count+1. core_reset_n and pll_ready go low on the same edge the state leaves RUN.
- force_relock=1 in WAIT_LOCK, QUALIFY or RUN -> PLL_RST next edge, counter cleared, core_reset_n=0, pll_ready=0.
- force_relock in PLL_RST is ignored; it does not extend the pulse.
- Neither counter increments on force_relock.
- force_relock has priority over the lock-drop and timeout transitions; that event is then not counted.
- Latency: pll_locked rising (stable before edge k) -> core_reset_n high at edge k+SYNC_STAGES+LOCK_STABLE_CYCLES.
- Latency: pll_locked falling in RUN -> core_reset_n low at edge k+SYNC_STAGES.
- Counters saturate at 2^CNT_W-1.
- clear_counts zeroes both counters. If an increment lands in the same cycle, clear wins.
- Cycle counter width: clog2 of the largest of PLL_RST_CYCLES, LOCK_STABLE_CYCLES and LOCK_TIMEOUT_CYCLES. The counter never wraps because every state exits before its terminal count.

Decomposition:
- Package pll_sup_pkg holds:
  - state enum {PLL_RST, WAIT_LOCK, QUALIFY, RUN}
  - a function computing the cycle counter width from the parameters
- One sub-module, pll_lock_sync: parameterised SYNC_STAGES bit synchronizer with reset-to-0. It is reused for other asynchronous status inputs.

Test Plan:
Bench parameters: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=100, CNT_W=2.
1. Release reset_n, pll_locked=0 for 5 cycles after pll_rst falls, then 1 -> pll_rst high exactly 4 cycles; core_reset_n rises 10 edges after pll_locked rises; pll_ready=1 with it.
2. pll_locked never asserts -> after 100 WAIT_LOCK cycles, pll_rst re-pulses 4 cycles; timeout_count increments 1,2,3,3 over four timeouts (saturation).
3. In RUN, drop pll_locked for 1 cycle -> core_reset_n low 2 edges later; lock_loss_count=1; PLL not re-reset; core_reset_n returns 10 edges after lock is re-seen.
4. pll_locked toggles 1 for 5 cycles, 0, then stays 1 -> no release during the glitch; release 10 edges after the final rise; counts unchanged.
5. force_relock in RUN, in the same cycle locked_s falls -> pll_rst high next edge for 4 cycles; lock_loss_count unchanged. clear_counts in the same cycle as a timeout leaves timeout_count=0.
6. reset_n low mid-QUALIFY -> next edge: pll_rst=1, core_reset_n=0, counts=0, state PLL_RST.
